// File: rtl/qspi_psram_emu.sv
// Oversampled serial PSRAM on a shared QSPI bus: SPI/QPI modes, fast/quad reads, quad writes, soft reset.
// Bus pins pass 2-flop synchronisers; outputs move 1 clk after a detected sck fall (<= 4 clk from the pin edge).
module qspi_psram_emu #(
    parameter int DEPTH_LOG2 = 16,
    parameter int QUAD_WAIT  = 6,
    parameter int FAST_WAIT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_n,
    input  logic       sck,
    input  logic [3:0] dio_in,
    output logic [3:0] dio_out,
    output logic [3:0] dio_oe
);
    localparam int AW = DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

    state_t        state;
    logic [2:0]    ce_s, sck_s;
    logic [3:0]    din_m, din_s;
    logic          ce_rise, ce_fall, sck_rise, sck_fall;
    logic          qpi, rst_en, set_qpi, clr_qpi, arm_rst;
    logic          aquad, dquad, is_rd;
    logic [7:0]    cmd, shreg, nwait, wcnt;
    logic [4:0]    cnt, cstep, astep, dstep;
    logic [AW-1:0] addr, addr_nxt, ra, wa;
    logic [7:0]    cmd_nxt, wsh, wd, rd_q;
    logic          re, we;
    logic [7:0]    mem [0:(1<<AW)-1];

    // Select history resets low so a reset taken with ce_n low cannot fake a select edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_s  <= '0;
            sck_s <= '0;
            din_m <= '0;
            din_s <= '0;
        end else begin
            ce_s  <= {ce_s[1:0], ce_n};
            sck_s <= {sck_s[1:0], sck};
            din_m <= dio_in;
            din_s <= din_m;
        end
    end

    assign ce_rise  =  ce_s[1]  & ~ce_s[2];
    assign ce_fall  = ~ce_s[1]  &  ce_s[2];
    assign sck_rise =  sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] &  sck_s[2];

    assign cstep    = qpi   ? 5'd4 : 5'd1;
    assign astep    = aquad ? 5'd4 : 5'd1;
    assign dstep    = dquad ? 5'd4 : 5'd1;
    assign cmd_nxt  = qpi   ? ((cmd << 4) | {4'b0, din_s}) : ((cmd << 1) | {7'b0, din_s[0]});
    assign addr_nxt = aquad ? ((addr << 4) | AW'(din_s))   : ((addr << 1) | AW'(din_s[0]));
    assign wsh      = dquad ? ((shreg << 4) | {4'b0, din_s}) : ((shreg << 1) | {7'b0, din_s[0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dio_out <= '0;
            dio_oe  <= '0;
            qpi     <= 1'b0;
            rst_en  <= 1'b0;
            set_qpi <= 1'b0;
            clr_qpi <= 1'b0;
            arm_rst <= 1'b0;
            aquad   <= 1'b0;
            dquad   <= 1'b0;
            is_rd   <= 1'b0;
            cmd     <= '0;
            shreg   <= '0;
            nwait   <= '0;
            wcnt    <= '0;
            cnt     <= '0;
            addr    <= '0;
            ra      <= '0;
            wa      <= '0;
            wd      <= '0;
            re      <= 1'b0;
            we      <= 1'b0;
        end else begin
            re <= 1'b0;
            we <= 1'b0;
            if (ce_rise) begin
                // Mode changes and the reset-enable arm take effect only when the select closes.
                state   <= IDLE;
                dio_oe  <= '0;
                dio_out <= '0;
                if (set_qpi)
                    qpi <= 1'b1;
                else if (clr_qpi)
                    qpi <= 1'b0;
                rst_en  <= arm_rst;
            end else if (ce_fall) begin
                state   <= CMD;
                cnt     <= '0;
                set_qpi <= 1'b0;
                clr_qpi <= 1'b0;
                arm_rst <= 1'b0;
            end else if (sck_rise) begin
                case (state)
                    CMD: begin
                        cmd <= cmd_nxt;
                        cnt <= cnt + cstep;
                        if (cnt + cstep == 5'd8) begin
                            cnt   <= '0;
                            state <= IGNORE;
                            is_rd <= 1'b0;
                            case (cmd_nxt)
                                8'h03: if (!qpi) begin
                                    state <= ADDR; aquad <= 1'b0; dquad <= 1'b0;
                                    nwait <= '0;   is_rd <= 1'b1;
                                end
                                8'h0B: begin
                                    state <= ADDR; aquad <= qpi; dquad <= qpi; is_rd <= 1'b1;
                                    nwait <= qpi ? 8'(QUAD_WAIT) : 8'(FAST_WAIT);
                                end
                                8'hEB: begin
                                    state <= ADDR; aquad <= 1'b1; dquad <= 1'b1;
                                    nwait <= 8'(QUAD_WAIT); is_rd <= 1'b1;
                                end
                                8'h02: begin state <= ADDR; aquad <= qpi;  dquad <= qpi;  end
                                8'h38: begin state <= ADDR; aquad <= 1'b1; dquad <= 1'b1; end
                                8'h35: set_qpi <= 1'b1;
                                8'hF5: clr_qpi <= 1'b1;
                                8'h66: arm_rst <= 1'b1;
                                8'h99: if (rst_en) clr_qpi <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    ADDR: begin
                        addr <= addr_nxt;
                        cnt  <= cnt + astep;
                        if (cnt + astep == 5'd24) begin
                            cnt <= '0;
                            if (is_rd) begin
                                re    <= 1'b1;
                                ra    <= addr_nxt;
                                addr  <= addr_nxt + 1'b1;
                                wcnt  <= '0;
                                state <= (nwait == 8'd0) ? RDATA : WAIT;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WAIT: begin
                        if (wcnt == nwait - 8'd1)
                            state <= RDATA;
                        else
                            wcnt <= wcnt + 8'd1;
                    end
                    WDATA: begin
                        shreg <= wsh;
                        if (cnt + dstep == 5'd8) begin
                            cnt  <= '0;
                            we   <= 1'b1;
                            wa   <= addr;
                            wd   <= wsh;
                            addr <= addr + 1'b1;
                        end else begin
                            cnt <= cnt + dstep;
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall && state == RDATA) begin
                // A byte starts straight from the read port; the next byte is fetched while it shifts out.
                if (cnt == 5'd0) begin
                    dio_out <= dquad ? rd_q[7:4] : {2'b00, rd_q[7], 1'b0};
                    shreg   <= dquad ? (rd_q << 4) : (rd_q << 1);
                    re      <= 1'b1;
                    ra      <= addr;
                    addr    <= addr + 1'b1;
                end else begin
                    dio_out <= dquad ? shreg[7:4] : {2'b00, shreg[7], 1'b0};
                    shreg   <= dquad ? (shreg << 4) : (shreg << 1);
                end
                cnt    <= (cnt + dstep == 5'd8) ? 5'd0 : cnt + dstep;
                dio_oe <= dquad ? 4'b1111 : 4'b0010;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        if (re)
            rd_q <= mem[ra];
    end

endmodule
